// File: rtl/muldiv_hilo_unit_if.sv
// Operand, control and HI/LO result bundle between control/register file and the mul/div unit.
interface muldiv_hilo_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] rs_data;
    logic [WIDTH-1:0] rt_data;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] hilo_wdata;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, rs_data, rt_data, hi_we, lo_we, hilo_wdata,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, rs_data, rt_data, hi_we, lo_we, hilo_wdata,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/muldiv_hilo_unit.sv
// Iterative shift-add multiplier / restoring divider with architectural HI/LO registers.
// Signed operations run on magnitudes; the sign is restored in the single FIX cycle.
module muldiv_hilo_unit #(
    parameter int WIDTH = 32
) (
    input  logic              clk,
    input  logic              reset,
    muldiv_hilo_unit_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t           state_reg, state_next;
    logic [CW-1:0]    cnt_reg;
    logic [WIDTH-1:0] a_reg;       // product high half / partial remainder
    logic [WIDTH-1:0] b_reg;       // multiplier then product low half / dividend then quotient
    logic [WIDTH-1:0] m_reg;       // multiplicand / divisor magnitude
    logic             is_div_reg;
    logic             q_neg_reg;   // product or quotient must be negated
    logic             r_neg_reg;   // remainder takes the dividend sign
    logic             dz_reg;
    logic             done_reg;
    logic [WIDTH-1:0] hi_reg, lo_reg;

    logic             signed_op;
    logic [WIDTH-1:0] rs_mag, rt_mag;
    logic [WIDTH:0]   mul_sum, div_shift, div_diff;
    logic [WIDTH-1:0] a_next, b_next;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0] quot_fix, rem_fix;

    always_ff @(posedge clk) begin
        if (reset) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (bus.start) state_next = CALC;
            CALC:    if (cnt_reg == '0) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        signed_op = ~bus.op[0];
        rs_mag    = (signed_op && bus.rs_data[WIDTH-1]) ? -bus.rs_data : bus.rs_data;
        rt_mag    = (signed_op && bus.rt_data[WIDTH-1]) ? -bus.rt_data : bus.rt_data;

        mul_sum   = {1'b0, a_reg} + (b_reg[0] ? {1'b0, m_reg} : '0);
        div_shift = {a_reg, b_reg[WIDTH-1]};
        div_diff  = div_shift - {1'b0, m_reg};

        if (is_div_reg) begin
            // Borrow out of the trial subtraction means "restore": keep the shifted remainder.
            a_next = div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
            b_next = {b_reg[WIDTH-2:0], ~div_diff[WIDTH]};
        end else begin
            a_next = mul_sum[WIDTH:1];
            b_next = {mul_sum[0], b_reg[WIDTH-1:1]};
        end

        prod     = {a_reg, b_reg};
        prod_fix = q_neg_reg ? -prod : prod;
        // Zero divisor leaves |dividend| in the remainder, so sign-restoring it yields rs unchanged.
        quot_fix = dz_reg ? '1 : (q_neg_reg ? -b_reg : b_reg);
        rem_fix  = r_neg_reg ? -a_reg : a_reg;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_reg    <= '0;
            a_reg      <= '0;
            b_reg      <= '0;
            m_reg      <= '0;
            is_div_reg <= 1'b0;
            q_neg_reg  <= 1'b0;
            r_neg_reg  <= 1'b0;
            dz_reg     <= 1'b0;
            done_reg   <= 1'b0;
            hi_reg     <= '0;
            lo_reg     <= '0;
        end else begin
            done_reg <= (state_reg == FIX);
            case (state_reg)
                IDLE: begin
                    if (bus.hi_we) hi_reg <= bus.hilo_wdata;
                    if (bus.lo_we) lo_reg <= bus.hilo_wdata;
                    if (bus.start) begin
                        cnt_reg    <= CW'(WIDTH - 1);
                        a_reg      <= '0;
                        b_reg      <= rs_mag;
                        m_reg      <= rt_mag;
                        is_div_reg <= bus.op[1];
                        q_neg_reg  <= signed_op && (bus.rs_data[WIDTH-1] ^ bus.rt_data[WIDTH-1]);
                        r_neg_reg  <= signed_op && bus.rs_data[WIDTH-1];
                        dz_reg     <= bus.op[1] && (bus.rt_data == '0);
                    end
                end
                CALC: begin
                    a_reg <= a_next;
                    b_reg <= b_next;
                    if (cnt_reg != '0) cnt_reg <= cnt_reg - 1'b1;
                end
                FIX: begin
                    if (is_div_reg) begin
                        hi_reg <= rem_fix;
                        lo_reg <= quot_fix;
                    end else begin
                        hi_reg <= prod_fix[2*WIDTH-1:WIDTH];
                        lo_reg <= prod_fix[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = (state_reg != IDLE);
    assign bus.done = done_reg;
    assign bus.hi   = hi_reg;
    assign bus.lo   = lo_reg;
endmodule
